serial_byte_receiver: RTL

Serial-to-parallel frame receiver: the receiving end of the serial link that the team's 8-bit shift register drives from its serial output. It samples one bit per `bit_en` strobe and detects a start bit. It shifts in WIDTH data bits, an optional even-parity bit and a stop bit, then presents the assembled word on a parallel output with a one-cycle valid pulse. Framing and parity errors are flagged, and the receiver re-arms only after the line returns idle-high.

---
 rtl/serial_rx_pkg.sv | 15 +
 rtl/serial_byte_receiver_if.sv | 22 ++
 rtl/rx_shift_reg.sv | 26 ++
 rtl/serial_byte_receiver.sv | 122 ++++++++++++
 4 files changed

// File: rtl/serial_rx_pkg.sv
// Shared types and line levels for the serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    localparam logic IdleLevel  = 1'b1;
    localparam logic StartLevel = 1'b0;

endpackage

// File: rtl/serial_byte_receiver_if.sv
// Serial line in, parallel word and status out, for the frame receiver.
interface serial_byte_receiver_if #(
    parameter int unsigned WIDTH = 8
);
    logic             bit_en;
    logic             sdi;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             frame_err;
    logic             parity_err;
    logic             busy;

    modport master (
        output bit_en, sdi,
        input  dout, dout_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  bit_en, sdi,
        output dout, dout_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/rx_shift_reg.sv
// Serial-in parallel-out shift register; direction chosen so the first bit lands at bit 0
// (LSB_FIRST=1) or at bit WIDTH-1 (LSB_FIRST=0).
module rx_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             sdi,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (shift_en) begin
            if (LSB_FIRST) begin
                q <= {sdi, q[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], sdi};
            end
        end
    end

endmodule

// File: rtl/serial_byte_receiver.sv
// Strobe-sampled serial frame receiver: start bit, WIDTH data bits, optional even parity,
// stop bit. Delivers the word with a one-cycle valid pulse and flags framing/parity errors.
module serial_byte_receiver
    import serial_rx_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    parameter bit          PARITY_EN = 1'b0
) (
    input logic                   clk,
    input logic                   reset,
    serial_byte_receiver_if.slave rx
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             perr_q, perr_d;
    logic             busy_q, busy_d;
    logic             shift_en;
    logic [WIDTH-1:0] shift_word;

    rx_shift_reg #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .shift_en(shift_en),
        .sdi     (rx.sdi),
        .q       (shift_word)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        dout_d   = dout_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        perr_d   = 1'b0;
        shift_en = 1'b0;

        if (rx.bit_en) begin
            unique case (state_q)
                StIdle: begin
                    if (rx.sdi == StartLevel) begin
                        state_d = StData;
                        cnt_d   = '0;
                        par_d   = 1'b0;
                    end
                end
                StData: begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_q + CntW'(1);
                    par_d    = par_q ^ rx.sdi;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = PARITY_EN ? StParity : StStop;
                    end
                end
                StParity: begin
                    par_d   = par_q ^ rx.sdi;
                    state_d = StStop;
                end
                StStop: begin
                    if (rx.sdi == IdleLevel) begin
                        dout_d  = shift_word;
                        valid_d = 1'b1;
                        perr_d  = PARITY_EN && par_q;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
                StBreak: begin
                    // A held-low line after a framing error must not look like a start bit.
                    if (rx.sdi == IdleLevel) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d == StData) || (state_d == StParity) || (state_d == StStop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
        end
    end

    assign rx.dout       = dout_q;
    assign rx.dout_valid = valid_q;
    assign rx.frame_err  = ferr_q;
    assign rx.parity_err = perr_q;
    assign rx.busy       = busy_q;

endmodule
